// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA read/write burst sequencers.
package dma_seq_pkg;

  localparam int DMA_ADDR_W     = 48;
  localparam int DMA_LEN_W      = 40;
  localparam int DMA_BYTE_WIDTH = 6;
  localparam int DMA_PAGE_BYTES = 4096;
  localparam int DMA_LINE_BYTES = 1 << DMA_BYTE_WIDTH;
  localparam int DMA_PAGE_LINES = DMA_PAGE_BYTES / DMA_LINE_BYTES;
  localparam int DMA_PAGE_W     = $clog2(DMA_PAGE_BYTES);

  // Encodings are exported on fsm_cs and decoded by dispatcher software.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CALC  = 4'd1,
    ST_ISSUE = 4'd2,
    ST_DRAIN = 4'd3,
    ST_DONE  = 4'd4
  } seq_state_e;

  // Layout of one entry in the DMA command queue.
  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  len;
  } dma_cmd_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min(MAX_BURST, lines left in command, lines left in page).
module dma_burst_calc
  import dma_seq_pkg::*;
#(
  parameter int LINES_W    = DMA_LEN_W - DMA_BYTE_WIDTH,
  parameter int BYTE_WIDTH = DMA_BYTE_WIDTH,
  parameter int MAX_BURST  = 64,
  parameter int PAGE_BYTES = DMA_PAGE_BYTES,
  parameter int BURST_W    = $clog2(MAX_BURST) + 1,
  parameter int LIP_W      = $clog2(PAGE_BYTES) - BYTE_WIDTH
) (
  input  logic [LINES_W-1:0] lines_left,
  input  logic [LIP_W-1:0]   line_in_page,
  output logic [BURST_W-1:0] burst
);

  localparam int PAGE_LINES = PAGE_BYTES >> BYTE_WIDTH;

  logic [LINES_W-1:0] page_room;

  assign page_room = LINES_W'(PAGE_LINES) - LINES_W'(line_in_page);

  // Running minimum compared at full width; the result never exceeds MAX_BURST.
  always_comb begin
    burst = BURST_W'(MAX_BURST);
    if (page_room < LINES_W'(burst))  burst = page_room[BURST_W-1:0];
    if (lines_left < LINES_W'(burst)) burst = lines_left[BURST_W-1:0];
  end

endmodule

// File: rtl/dma_rd_burst_sequencer.sv
// Read-side DMA sequencer: splits one command into page-safe line bursts,
// throttles on outstanding-line credit and signals completion.
module dma_rd_burst_sequencer
  import dma_seq_pkg::*;
#(
  parameter int ADDR_WIDTH        = DMA_ADDR_W,
  parameter int XFER_LENGTH_WIDTH = DMA_LEN_W,
  parameter int BYTE_WIDTH        = DMA_BYTE_WIDTH,
  parameter int MAX_BURST         = 64,
  parameter int PAGE_BYTES        = DMA_PAGE_BYTES,
  parameter int MAX_OUTSTANDING   = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sclr,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_src,
  input  logic [ADDR_WIDTH-1:0]        cmd_dst,
  input  logic [XFER_LENGTH_WIDTH-1:0] cmd_len,
  output logic                         rd_req_valid,
  input  logic                         rd_req_ready,
  output logic [ADDR_WIDTH-1:0]        rd_req_addr,
  output logic [$clog2(MAX_BURST):0]   rd_req_burstcnt,
  input  logic                         rsp_valid,
  output logic [ADDR_WIDTH-1:0]        cur_dst,
  output logic                         busy,
  output logic                         irq,
  output logic                         irq_pulse,
  input  logic                         clear_irq,
  output logic                         err_unaligned,
  output logic                         err_rsp_overflow,
  output logic [3:0]                   fsm_cs,
  output logic [15:0]                  xfer_remaining
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int LINES_W = XFER_LENGTH_WIDTH - BYTE_WIDTH;
  localparam int PAGE_W  = $clog2(PAGE_BYTES);

  seq_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LINES_W-1:0]  lines_left;
  logic [OUT_W-1:0]    outstanding;
  logic [BURST_W-1:0]  burst_q, burst_calc;
  logic                accept, issue, credit_ok, last_burst, rsp_ok;

  assign accept     = cmd_valid && cmd_ready;
  assign issue      = rd_req_valid && rd_req_ready;
  assign credit_ok  = ((OUT_W+1)'(outstanding) + (OUT_W+1)'(burst_q)) <= (OUT_W+1)'(MAX_OUTSTANDING);
  assign last_burst = (lines_left == LINES_W'(burst_q));
  assign rsp_ok     = rsp_valid && (outstanding != '0);

  dma_burst_calc #(
    .LINES_W    (LINES_W),
    .BYTE_WIDTH (BYTE_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .PAGE_BYTES (PAGE_BYTES)
  ) u_burst_calc (
    .lines_left   (lines_left),
    .line_in_page (cur_addr[PAGE_W-1:BYTE_WIDTH]),
    .burst        (burst_calc)
  );

  // State register; sclr returns to IDLE ahead of any transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     state <= ST_IDLE;
    else if (sclr) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    rd_req_valid = 1'b0;
    irq_pulse    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = !sclr && !reset;
        if (cmd_valid && !sclr && !reset) state_nxt = ST_CALC;
      end
      ST_CALC:  state_nxt = (lines_left == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        rd_req_valid = credit_ok;
        if (credit_ok && rd_req_ready) state_nxt = last_burst ? ST_DRAIN : ST_CALC;
      end
      ST_DRAIN: if (outstanding == '0) state_nxt = ST_DONE;
      ST_DONE: begin
        irq_pulse = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, burst size capture and address/length advance per issued burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr   <= '0;
      cur_dst    <= '0;
      lines_left <= '0;
      burst_q    <= '0;
    end else if (sclr) begin
      cur_addr   <= '0;
      cur_dst    <= '0;
      lines_left <= '0;
      burst_q    <= '0;
    end else begin
      if (accept) begin
        cur_addr   <= {cmd_src[ADDR_WIDTH-1:BYTE_WIDTH], {BYTE_WIDTH{1'b0}}};
        cur_dst    <= cmd_dst;
        lines_left <= cmd_len[XFER_LENGTH_WIDTH-1:BYTE_WIDTH];
      end
      if (state == ST_CALC) burst_q <= burst_calc;
      if (issue) begin
        cur_addr   <= cur_addr + (ADDR_WIDTH'(burst_q) << BYTE_WIDTH);
        lines_left <= lines_left - LINES_W'(burst_q);
      end
    end
  end

  // Outstanding-line credit; a response with nothing outstanding is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     outstanding <= '0;
    else if (sclr) outstanding <= '0;
    else           outstanding <= outstanding + (issue ? OUT_W'(burst_q) : '0) - OUT_W'(rsp_ok);
  end

  // Sticky completion and error flags; a completion beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq              <= 1'b0;
      err_unaligned    <= 1'b0;
      err_rsp_overflow <= 1'b0;
    end else if (sclr) begin
      irq              <= 1'b0;
      err_unaligned    <= 1'b0;
      err_rsp_overflow <= 1'b0;
    end else begin
      if (irq_pulse)      irq <= 1'b1;
      else if (clear_irq) irq <= 1'b0;
      if (accept && ((|cmd_src[BYTE_WIDTH-1:0]) || (|cmd_len[BYTE_WIDTH-1:0])))
        err_unaligned <= 1'b1;
      if (rsp_valid && (outstanding == '0))
        err_rsp_overflow <= 1'b1;
    end
  end

  assign busy            = (state != ST_IDLE);
  assign fsm_cs          = state;
  assign rd_req_addr     = cur_addr;
  assign rd_req_burstcnt = burst_q;
  assign xfer_remaining  = (|lines_left[LINES_W-1:16]) ? 16'hFFFF : lines_left[15:0];

endmodule
